avmm_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one FPGA-side Avalon-MM master port between NUM_REQ requesters, for example the RISC-V core fetch and data ports plus a debug/DMA engine.
- The master port drives the FPGA-to-HPS bridge or an on-chip memory.
- Issues one command at a time and supports up to MAX_OUTST pipelined reads.
- Routes each read response back to the requester that issued it, using an in-order ID FIFO.

---
 rtl/avmm_arb_pkg.sv | 47 ++++
 rtl/avmm_arb_id_fifo.sv | 72 +++++++
 rtl/avmm_rr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_avmm_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared types and helpers for the Avalon-MM round-robin arbiter:
// FSM state encoding, id-width helper and the rotating-priority pick.
package avmm_arb_pkg;

  // Widest configuration supported (NUM_REQ up to 8).
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Result of a round-robin search: valid winner flag plus its index.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // Bits needed to name one requester (at least one bit).
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // First set bit of mask searching upward from last_gnt+1, modulo num_req.
  // mask bits at or above num_req are never looked at.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0]  mask,
    input logic [MAX_ID_W-1:0] last_gnt,
    input int                  num_req
  );
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = (int'(last_gnt) + k) % num_req;
      if ((k <= num_req) && !pick.valid && mask[cand[MAX_ID_W-1:0]]) begin
        pick.valid = 1'b1;
        pick.idx   = cand[MAX_ID_W-1:0];
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/avmm_arb_id_fifo.sv
// In-order FIFO of requester ids for reads in flight. One entry is pushed
// per accepted read and popped per readdatavalid; both may happen in the
// same cycle. DEPTH must be a power of two so pointers wrap naturally.
module avmm_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Status flags and qualified push/pop; a push into a full FIFO is only
  // allowed when an entry leaves in the same cycle.
  always_comb begin
    full_s    = (count_r == CNT_FULL);
    empty_s   = (count_r == '0);
    pop_ok_s  = pop && !empty_s;
    push_ok_s = push && (!full_s || pop_ok_s);
  end

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/avmm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between NUM_REQ
// requesters. One command is on the bus at a time; up to MAX_OUTST reads
// may be outstanding, and their responses are steered back to the issuing
// requester through an in-order id FIFO.
module avmm_rr_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_be,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_read,
  output logic                          avm_write,
  output logic [DATA_W-1:0]             avm_writedata,
  output logic [DATA_W/8-1:0]           avm_byteenable,
  input  logic                          avm_waitrequest,
  input  logic [DATA_W-1:0]             avm_readdata,
  input  logic                          avm_readdatavalid,
  output logic [$clog2(MAX_OUTST):0]    outst_cnt,
  output logic                          err_rdv
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ID_W-1:0] LAST_GNT_RST = ID_W'(NUM_REQ - 1);

  arb_state_e              state_r;
  arb_state_e              state_nxt_s;
  logic [ID_W-1:0]         last_gnt_r;
  logic [ID_W-1:0]         id_r;
  logic [ID_W-1:0]         win_idx_s;
  logic [NUM_REQ-1:0]      eligible_s;
  logic [MAX_REQ-1:0]      mask_s;
  logic [MAX_ID_W-1:0]     last_ext_s;
  rr_pick_t                pick_s;
  logic                    grant_s;
  logic                    accept_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [ID_W-1:0]         fifo_head_s;
  logic [$clog2(MAX_OUTST):0] fifo_cnt_s;
  logic [NUM_REQ-1:0]      rsp_onehot_s;

  // Eligibility and round-robin winner: a full id FIFO holds back reads
  // only, so writes keep flowing while reads are backed up.
  always_comb begin
    eligible_s = req_valid & (req_write | {NUM_REQ{~fifo_full_s}});
    mask_s     = '0;
    mask_s[NUM_REQ-1:0] = eligible_s;
    last_ext_s = '0;
    last_ext_s[ID_W-1:0] = last_gnt_r;
    pick_s     = rr_pick(mask_s, last_ext_s, NUM_REQ);
    win_idx_s  = pick_s.idx[ID_W-1:0];
  end

  // Next-state logic: grant from IDLE, complete in ISSUE once the slave
  // stops stalling.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s.valid) begin
          state_nxt_s = ISSUE;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          state_nxt_s = IDLE;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accept pulse lands in the very cycle the slave takes the command, so
  // the requester can retire its payload on the same edge.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[id_r] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Read completion pushes the issuer id; readdatavalid pops it unless
  // nothing is outstanding.
  always_comb begin
    push_s = accept_s & avm_read;
    pop_s  = avm_readdatavalid & ~fifo_empty_s;
  end

  // Command register: load the winner's payload on grant, drop the strobe
  // once accepted and move the round-robin pointer to the served id.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      id_r           <= '0;
      last_gnt_r     <= LAST_GNT_RST;
    end else if (grant_s) begin
      avm_address    <= req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
      avm_writedata  <= req_wdata[int'(win_idx_s)*DATA_W +: DATA_W];
      avm_byteenable <= req_be[int'(win_idx_s)*BE_W +: BE_W];
      avm_write      <= req_write[win_idx_s];
      avm_read       <= ~req_write[win_idx_s];
      id_r           <= win_idx_s;
    end else if (accept_s) begin
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      last_gnt_r     <= id_r;
    end
  end

  // One-hot select of the requester at the head of the id FIFO.
  always_comb begin
    rsp_onehot_s = '0;
    rsp_onehot_s[fifo_head_s] = 1'b1;
  end

  // Response path: one-cycle rsp_valid pulse to the owner, rdata held
  // between responses, sticky flag for a response nobody asked for.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      err_rdv   <= 1'b0;
    end else begin
      if (pop_s) begin
        rsp_valid <= rsp_onehot_s;
        rsp_rdata <= avm_readdata;
      end else begin
        rsp_valid <= '0;
      end
      if (avm_readdatavalid && fifo_empty_s) begin
        err_rdv <= 1'b1;
      end
    end
  end

  avmm_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (ID_W)
  ) u_id_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (push_s),
    .push_data (id_r),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_cnt_s)
  );

  assign outst_cnt = fifo_cnt_s;

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Directed bench for avmm_rr_arbiter with NUM_REQ=3, 32-bit address/data,
// MAX_OUTST=4. The slave side is driven by hand step by step.
module tb_avmm_rr_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [95:0] req_addr;
  logic [95:0] req_wdata;
  logic [11:0] req_be;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [2:0]  outst_cnt;
  logic        err_rdv;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk_clk = ~clk_clk;

  avmm_rr_arbiter #(
    .NUM_REQ   (3),
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_OUTST (4)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_be            (req_be),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .outst_cnt         (outst_cnt),
    .err_rdv           (err_rdv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int i);
    return 3'(3'b001 << i);
  endfunction

  // Move to just after the next rising edge.
  task automatic nxt();
    @(posedge clk_clk);
    #1;
  endtask

  // Let combinational outputs settle, still well before the falling edge.
  task automatic settle();
    #3;
  endtask

  // One command from requester idx; holds valid until ready (bounded).
  task automatic do_cmd(input logic [1:0] idx, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    logic got;
    req_valid[idx]          = 1'b1;
    req_write[idx]          = wr;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wd;
    req_be[idx*4 +: 4]      = 4'hF;
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (!got) begin
        nxt();
        settle();
        got = (req_ready != 3'b000);
      end
    end
    chk({tag, "_ready"}, 64'(req_ready), 64'(oh(int'(idx))));
    chk({tag, "_addr"}, 64'(avm_address), 64'(addr));
    chk({tag, "_rw"}, 64'({avm_write, avm_read}), 64'(wr ? 2'b10 : 2'b01));
    nxt();
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    logic got;
    int   exp_id;

    reset_reset_n     = 1'b0;
    req_valid         = 3'b000;
    req_write         = 3'b000;
    req_addr          = 96'h0;
    req_wdata         = 96'h0;
    req_be            = 12'h0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = 32'h0;
    avm_readdatavalid = 1'b0;

    // Reset state
    repeat (3) nxt();
    reset_reset_n = 1'b1;
    settle();
    chk("rst_read", 64'(avm_read), 64'(1'b0));
    chk("rst_write", 64'(avm_write), 64'(1'b0));
    chk("rst_ready", 64'(req_ready), 64'(3'b000));
    chk("rst_rsp", 64'(rsp_valid), 64'(3'b000));
    chk("rst_cnt", 64'(outst_cnt), 64'(3'd0));
    chk("rst_err", 64'(err_rdv), 64'(1'b0));
    chk("rst_addr", 64'(avm_address), 64'(32'h0));

    // Single read, zero wait states, data two cycles after the command
    req_valid      = 3'b001;
    req_write      = 3'b000;
    req_addr[31:0] = 32'h100;
    req_be[3:0]    = 4'hF;
    nxt(); settle();
    chk("sr_read", 64'(avm_read), 64'(1'b1));
    chk("sr_addr", 64'(avm_address), 64'(32'h100));
    chk("sr_ready", 64'(req_ready), 64'(3'b001));
    chk("sr_be", 64'(avm_byteenable), 64'(4'hF));
    nxt(); req_valid = 3'b000; settle();
    chk("sr_read_off", 64'(avm_read), 64'(1'b0));
    chk("sr_ready_off", 64'(req_ready), 64'(3'b000));
    chk("sr_cnt1", 64'(outst_cnt), 64'(3'd1));
    nxt(); avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF; settle();
    chk("sr_rsp_early", 64'(rsp_valid), 64'(3'b000));
    nxt(); avm_readdatavalid = 1'b0; settle();
    chk("sr_rsp", 64'(rsp_valid), 64'(3'b001));
    chk("sr_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    chk("sr_cnt0", 64'(outst_cnt), 64'(3'd0));
    nxt(); settle();
    chk("sr_rsp_once", 64'(rsp_valid), 64'(3'b000));
    chk("sr_rdata_hold", 64'(rsp_rdata), 64'(32'hDEADBEEF));

    // Fairness: all three keep writing; last grant was 0, so 1,2,0,...
    req_addr  = {32'h1200, 32'h1100, 32'h1000};
    req_write = 3'b111;
    req_valid = 3'b111;
    exp_id    = 0;
    for (int g = 0; g < 18; g++) begin
      exp_id = (exp_id + 1) % 3;
      got = 1'b0;
      for (int n = 0; n < 6; n++) begin
        if (!got) begin
          nxt(); settle();
          got = (req_ready != 3'b000);
        end
      end
      chk("fair_grant", 64'(req_ready), 64'(oh(exp_id)));
      chk("fair_addr", 64'(avm_address), 64'(32'h1000 + 32'(exp_id) * 32'h100));
    end
    nxt(); req_valid = 3'b000; req_write = 3'b000; settle();
    chk("fair_cnt", 64'(outst_cnt), 64'(3'd0));

    // Waitrequest stall on a write from requester 1
    avm_waitrequest   = 1'b1;
    req_valid         = 3'b010;
    req_write         = 3'b010;
    req_addr[63:32]   = 32'h200;
    req_wdata[63:32]  = 32'h55AA1234;
    req_be[7:4]       = 4'h3;
    for (int s = 0; s < 3; s++) begin
      nxt(); settle();
      chk("st_write", 64'(avm_write), 64'(1'b1));
      chk("st_addr", 64'(avm_address), 64'(32'h200));
      chk("st_wait_ready", 64'(req_ready), 64'(3'b000));
    end
    nxt(); avm_waitrequest = 1'b0; settle();
    chk("st_ready", 64'(req_ready), 64'(3'b010));
    chk("st_wdata", 64'(avm_writedata), 64'(32'h55AA1234));
    chk("st_be", 64'(avm_byteenable), 64'(4'h3));
    chk("st_write4", 64'(avm_write), 64'(1'b1));
    nxt(); req_valid = 3'b000; req_write = 3'b000; settle();
    chk("st_done", 64'(avm_write), 64'(1'b0));
    chk("st_cnt", 64'(outst_cnt), 64'(3'd0));

    // FIFO full: four reads without responses
    for (int k = 0; k < 4; k++) begin
      do_cmd(2'd0, 1'b0, 32'h400 + 32'(k) * 32'h4, 32'h0, "ff_rd");
    end
    settle();
    chk("ff_cnt4", 64'(outst_cnt), 64'(3'd4));
    req_valid[2]     = 1'b1;
    req_write[2]     = 1'b0;
    req_addr[95:64]  = 32'h600;
    do_cmd(2'd0, 1'b1, 32'h500, 32'hCAFE, "ff_wr");
    settle();
    for (int k = 0; k < 3; k++) begin
      nxt(); settle();
      chk("ff_block", 64'(req_ready), 64'(3'b000));
      chk("ff_idle", 64'(avm_read), 64'(1'b0));
    end
    chk("ff_cnt_hold", 64'(outst_cnt), 64'(3'd4));
    avm_readdatavalid = 1'b1; avm_readdata = 32'h11111111;
    nxt(); avm_readdatavalid = 1'b0; settle();
    chk("ff_rsp", 64'(rsp_valid), 64'(3'b001));
    chk("ff_cnt3", 64'(outst_cnt), 64'(3'd3));
    chk("ff_nogrant", 64'(req_ready), 64'(3'b000));
    nxt(); settle();
    chk("ff_grant2", 64'(req_ready), 64'(3'b100));
    chk("ff_addr2", 64'(avm_address), 64'(32'h600));
    nxt(); req_valid = 3'b000; settle();
    chk("ff_cnt4b", 64'(outst_cnt), 64'(3'd4));
    for (int k = 0; k < 4; k++) begin
      avm_readdatavalid = 1'b1; avm_readdata = 32'hD0 + 32'(k);
      nxt(); avm_readdatavalid = 1'b0; settle();
      chk("ff_drain_id", 64'(rsp_valid), 64'(oh(k == 3 ? 2 : 0)));
      chk("ff_drain_data", 64'(rsp_rdata), 64'(32'hD0 + 32'(k)));
    end
    chk("ff_cnt_empty", 64'(outst_cnt), 64'(3'd0));

    // Response routing: reads from 2, 0, 1; data A, B, C
    do_cmd(2'd2, 1'b0, 32'h700, 32'h0, "rt2");
    do_cmd(2'd0, 1'b0, 32'h704, 32'h0, "rt0");
    do_cmd(2'd1, 1'b0, 32'h708, 32'h0, "rt1");
    settle();
    chk("rt_cnt3", 64'(outst_cnt), 64'(3'd3));
    for (int k = 0; k < 3; k++) begin
      avm_readdatavalid = 1'b1; avm_readdata = 32'hAAAA0000 + 32'(k);
      nxt(); avm_readdatavalid = 1'b0; settle();
      chk("rt_id", 64'(rsp_valid), 64'(oh(k == 0 ? 2 : (k == 1 ? 0 : 1))));
      chk("rt_data", 64'(rsp_rdata), 64'(32'hAAAA0000 + 32'(k)));
    end

    // Unexpected readdatavalid with nothing outstanding
    avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD0BAD0;
    nxt(); avm_readdatavalid = 1'b0; settle();
    chk("err_set", 64'(err_rdv), 64'(1'b1));
    chk("err_norsp", 64'(rsp_valid), 64'(3'b000));
    nxt(); settle();
    chk("err_sticky", 64'(err_rdv), 64'(1'b1));

    // Asynchronous reset while a read is stalled in ISSUE
    do_cmd(2'd1, 1'b0, 32'h800, 32'h0, "rs");
    settle();
    chk("rs_cnt1", 64'(outst_cnt), 64'(3'd1));
    avm_waitrequest = 1'b1;
    req_valid[0]    = 1'b1;
    req_write[0]    = 1'b0;
    nxt(); settle();
    chk("rs_issue", 64'(avm_read), 64'(1'b1));
    reset_reset_n = 1'b0;
    #1;
    chk("rs_read", 64'(avm_read), 64'(1'b0));
    chk("rs_write", 64'(avm_write), 64'(1'b0));
    chk("rs_cnt0", 64'(outst_cnt), 64'(3'd0));
    chk("rs_err", 64'(err_rdv), 64'(1'b0));
    chk("rs_ready", 64'(req_ready), 64'(3'b000));
    nxt(); req_valid = 3'b000; avm_waitrequest = 1'b0;
    nxt(); reset_reset_n = 1'b1; settle();
    chk("rs_after", 64'(avm_read), 64'(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
